// File: rtl/usb_arb_pkg.sv
// Shared types and constants for the USB / CPU memory-port arbiter.
package usb_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_CPU,
    GNT_USB_WR,
    GNT_USB_RD
  } gnt_owner_t;

  // Byte count to 16-bit word count, rounding up; 17 bits so 0xFFFF+1 cannot wrap.
  function automatic logic [16:0] bytes_to_words(input logic [15:0] bytes);
    return ({1'b0, bytes} + 17'd1) >> 1;
  endfunction

endpackage

// File: rtl/usb_wr_queue.sv
// Small power-of-two FIFO buffering posted USB writes as {addr, data} entries.
module usb_wr_queue #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       CLK_SYS,
  input  logic                       RESET_N,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK_SYS) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge CLK_SYS) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/usb_mem_arbiter.sv
// Shares one 16-bit memory port between buffered USB writes, USB burst reads and the CPU bus.
module usb_mem_arbiter
  import usb_arb_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int WQ_DEPTH = 4
) (
  input  logic              CLK_SYS,
  input  logic              RESET_N,
  input  logic              USB_WRITE_PULSE,
  input  logic              USB_READ_PULSE,
  input  logic [31:0]       USB_ADDR,
  input  logic [15:0]       USB_DO,
  input  logic [15:0]       USB_BYTE_COUNT,
  output logic [15:0]       USB_DI,
  output logic              usb_rd_valid,
  input  logic              usb_rd_ready,
  output logic              usb_rd_busy,
  output logic              wq_full,
  output logic              wq_overflow,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_dout,
  output logic [15:0]       cpu_din,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int QW = ADDR_W + DATA_W;
  localparam int CW = $clog2(WQ_DEPTH) + 1;

  arb_state_t        state;
  gnt_owner_t        owner;
  logic              rr_usb;
  logic [ADDR_W-1:0] rd_addr;
  logic [16:0]       rd_words;
  logic              wq_pop;
  logic              wq_empty;
  logic [QW-1:0]     wq_head;
  logic [CW-1:0]     wq_count;
  logic              usb_pend;
  logic              cpu_pend;
  logic              pick_usb;
  logic              rd_start;
  logic              unused_bits;

  assign unused_bits = ^{USB_ADDR, cpu_addr[0], wq_count};

  usb_wr_queue #(.W(QW), .DEPTH(WQ_DEPTH)) u_wr_queue (
    .CLK_SYS   (CLK_SYS),
    .RESET_N   (RESET_N),
    .push      (USB_WRITE_PULSE),
    .push_data ({USB_ADDR[ADDR_W-1:1], 1'b0, USB_DO}),
    .pop       (wq_pop),
    .head      (wq_head),
    .full      (wq_full),
    .empty     (wq_empty),
    .count     (wq_count)
  );

  assign wq_pop   = (state == ACCESS) && mem_ack && (owner == GNT_USB_WR);
  assign rd_start = USB_READ_PULSE && !usb_rd_busy && (USB_BYTE_COUNT != '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    usb_pend = 1'b0;
    cpu_pend = 1'b0;
    pick_usb = 1'b0;
    // Reads wait behind queued writes so a read-back always sees the posted data.
    usb_pend = !wq_empty || (usb_rd_busy && wq_empty && !usb_rd_valid);
    // cpu_req is still high during the ack cycle; masking it avoids re-granting a finished access.
    cpu_pend = cpu_req && !cpu_ack;
    if (state == IDLE) pick_usb = usb_pend && (!cpu_pend || rr_usb);
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RESET_N) begin
      state        <= IDLE;
      owner        <= GNT_CPU;
      rr_usb       <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_din      <= '0;
      cpu_ack      <= 1'b0;
      USB_DI       <= '0;
      usb_rd_valid <= 1'b0;
      usb_rd_busy  <= 1'b0;
      rd_addr      <= '0;
      rd_words     <= '0;
      wq_overflow  <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      if (USB_WRITE_PULSE && wq_full) wq_overflow <= 1'b1;
      if (rd_start) begin
        usb_rd_busy <= 1'b1;
        rd_addr     <= {USB_ADDR[ADDR_W-1:1], 1'b0};
        rd_words    <= bytes_to_words(USB_BYTE_COUNT);
      end

      case (state)
        IDLE: begin
          if (pick_usb) begin
            state   <= ACCESS;
            mem_req <= 1'b1;
            rr_usb  <= 1'b0;
            if (!wq_empty) begin
              owner     <= GNT_USB_WR;
              mem_we    <= 1'b1;
              mem_addr  <= wq_head[QW-1:DATA_W];
              mem_wdata <= wq_head[DATA_W-1:0];
            end else begin
              owner    <= GNT_USB_RD;
              mem_we   <= 1'b0;
              mem_addr <= rd_addr;
            end
          end else if (cpu_pend) begin
            state     <= ACCESS;
            mem_req   <= 1'b1;
            rr_usb    <= 1'b1;
            owner     <= GNT_CPU;
            mem_we    <= cpu_we;
            mem_addr  <= {cpu_addr[ADDR_W-1:1], 1'b0};
            mem_wdata <= cpu_dout;
          end
        end

        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (owner)
              GNT_CPU: begin
                if (!mem_we) cpu_din <= mem_rdata;
                cpu_ack <= 1'b1;
                state   <= IDLE;
              end
              GNT_USB_RD: begin
                USB_DI       <= mem_rdata;
                usb_rd_valid <= 1'b1;
                state        <= RDWAIT;
              end
              default: state <= IDLE;
            endcase
          end
        end

        RDWAIT: begin
          if (usb_rd_valid && usb_rd_ready) begin
            usb_rd_valid <= 1'b0;
            rd_addr      <= rd_addr + ADDR_W'(2);
            rd_words     <= rd_words - 17'd1;
            if (rd_words == 17'd1) usb_rd_busy <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_mem_arbiter.sv
// Scoreboard bench for usb_mem_arbiter: a latency-2 memory model, a CPU agent and USB stimulus tasks.
module tb_usb_mem_arbiter;
  import usb_arb_pkg::*;

  localparam int ADDR_W   = 24;
  localparam int WQ_DEPTH = 4;
  localparam int ACK_DLY  = 2;

  logic              CLK_SYS;
  logic              RESET_N;
  logic              USB_WRITE_PULSE;
  logic              USB_READ_PULSE;
  logic [31:0]       USB_ADDR;
  logic [15:0]       USB_DO;
  logic [15:0]       USB_BYTE_COUNT;
  logic [15:0]       USB_DI;
  logic              usb_rd_valid;
  logic              usb_rd_ready;
  logic              usb_rd_busy;
  logic              wq_full;
  logic              wq_overflow;
  logic              cpu_req  = 1'b0;
  logic              cpu_we   = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [15:0]       cpu_dout = '0;
  logic [15:0]       cpu_din;
  logic              cpu_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = '0;
  logic              mem_ack   = 1'b0;

  usb_mem_arbiter #(.ADDR_W(ADDR_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .CLK_SYS         (CLK_SYS),
    .RESET_N         (RESET_N),
    .USB_WRITE_PULSE (USB_WRITE_PULSE),
    .USB_READ_PULSE  (USB_READ_PULSE),
    .USB_ADDR        (USB_ADDR),
    .USB_DO          (USB_DO),
    .USB_BYTE_COUNT  (USB_BYTE_COUNT),
    .USB_DI          (USB_DI),
    .usb_rd_valid    (usb_rd_valid),
    .usb_rd_ready    (usb_rd_ready),
    .usb_rd_busy     (usb_rd_busy),
    .wq_full         (wq_full),
    .wq_overflow     (wq_overflow),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_dout        (cpu_dout),
    .cpu_din         (cpu_din),
    .cpu_ack         (cpu_ack),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack)
  );

  initial CLK_SYS = 1'b0;
  always #5 CLK_SYS = ~CLK_SYS;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } txn_t;

  txn_t        exp_mem[$];
  logic [15:0] exp_rd[$];
  txn_t        cpu_q[$];
  txn_t        cpu_cur;
  bit          cpu_active = 1'b0;
  logic [15:0] mem_model [int];
  bit          hold_ack = 1'b0;
  int          wait_cnt = 0;
  int          mem_acc_cnt = 0;
  int          cpu_ack_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Memory controller: acks ACK_DLY cycles after req unless stalled; checks each access against the scoreboard.
  always @(negedge CLK_SYS) begin : mem_model_p
    txn_t t;
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (!mem_req) begin
      wait_cnt = 0;
    end else if (!hold_ack) begin
      wait_cnt++;
      if (wait_cnt >= ACK_DLY) begin
        mem_ack = 1'b1;
        mem_acc_cnt++;
        if (exp_mem.size() == 0) begin
          check("mem_extra_access", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          t = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(t.we));
          check("mem_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) check("mem_wdata", 32'(mem_wdata), 32'(t.data));
        end
        if (mem_we) mem_model[int'(mem_addr)] = mem_wdata;
        else mem_rdata = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 16'hDEAD;
      end
    end
  end

  // CPU agent: holds each request until cpu_ack, then presents the next one immediately.
  always @(negedge CLK_SYS) begin
    if (cpu_ack) begin
      cpu_ack_cnt++;
      if (!cpu_active) check("cpu_ack_spurious", 32'(cpu_ack), 32'h0);
      else begin
        if (!cpu_cur.we) check("cpu_din", 32'(cpu_din), 32'(cpu_cur.data));
        cpu_active = 1'b0;
      end
    end
    if (!cpu_active && cpu_q.size() > 0) begin
      cpu_cur    = cpu_q.pop_front();
      cpu_active = 1'b1;
      cpu_req    = 1'b1;
      cpu_we     = cpu_cur.we;
      cpu_addr   = cpu_cur.addr;
      cpu_dout   = cpu_cur.data;
    end else if (!cpu_active) begin
      cpu_req = 1'b0;
    end
  end

  task automatic usb_write(input logic [31:0] a, input logic [15:0] d, input bit accept);
    @(negedge CLK_SYS);
    USB_READ_PULSE  = 1'b0;
    USB_WRITE_PULSE = 1'b1;
    USB_ADDR        = a;
    USB_DO          = d;
    if (accept) exp_mem.push_back('{we: 1'b1, addr: {a[ADDR_W-1:1], 1'b0}, data: d});
  endtask

  task automatic usb_read(input logic [31:0] a, input logic [15:0] bytes);
    @(negedge CLK_SYS);
    USB_WRITE_PULSE = 1'b0;
    USB_READ_PULSE  = 1'b1;
    USB_ADDR        = a;
    USB_BYTE_COUNT  = bytes;
  endtask

  task automatic usb_quiet();
    @(negedge CLK_SYS);
    USB_WRITE_PULSE = 1'b0;
    USB_READ_PULSE  = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int n = 0;
    while ((exp_mem.size() != 0 || mem_req || usb_rd_busy || cpu_active || cpu_q.size() != 0)
           && n < max_cyc) begin
      @(negedge CLK_SYS);
      n++;
    end
    check({tag, "_pending"}, 32'(exp_mem.size()), 32'h0);
    check({tag, "_idle"}, 32'({mem_req, usb_rd_busy, cpu_active}), 32'h0);
  endtask

  // Accepts n burst words; optionally stalls the first one for 4 cycles to check it holds.
  task automatic consume_words(input int n, input bit stall_first);
    logic [15:0] want;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!usb_rd_valid && t < 100) begin
        @(negedge CLK_SYS);
        t++;
      end
      if (!usb_rd_valid) begin
        check("rd_valid_timeout", 32'(usb_rd_valid), 32'h1);
        return;
      end
      want = (exp_rd.size() > 0) ? exp_rd.pop_front() : 16'hXXXX;
      check("usb_di", 32'(USB_DI), 32'(want));
      if (stall_first && k == 0) begin
        repeat (4) begin
          @(negedge CLK_SYS);
          check("usb_di_hold", 32'({usb_rd_valid, USB_DI}), 32'({1'b1, want}));
        end
      end
      usb_rd_ready = 1'b1;
      @(negedge CLK_SYS);
      check("rd_valid_drop", 32'(usb_rd_valid), 32'h0);
      check("rd_busy_after_hs", 32'(usb_rd_busy), 32'(k != n - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int base;
    int ack0;
    RESET_N         = 1'b0;
    USB_WRITE_PULSE = 1'b0;
    USB_READ_PULSE  = 1'b0;
    USB_ADDR        = '0;
    USB_DO          = '0;
    USB_BYTE_COUNT  = '0;
    usb_rd_ready    = 1'b1;

    // Reset state
    repeat (3) @(negedge CLK_SYS);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_rd_valid", 32'(usb_rd_valid), 0);
    check("rst_rd_busy", 32'(usb_rd_busy), 0);
    check("rst_wq_full", 32'(wq_full), 0);
    check("rst_wq_ovf", 32'(wq_overflow), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_usb_di", 32'(USB_DI), 0);
    check("rst_cpu_din", 32'(cpu_din), 0);
    RESET_N = 1'b1;

    // Three posted writes reach memory in order
    base = mem_acc_cnt;
    ack0 = cpu_ack_cnt;
    usb_write(32'h100, 16'hAAAA, 1'b1);
    usb_write(32'h102, 16'hBBBB, 1'b1);
    usb_write(32'h104, 16'hCCCC, 1'b1);
    usb_quiet();
    wait_drain(200, "t1");
    check("t1_mem_count", 32'(mem_acc_cnt - base), 3);
    check("t1_no_cpu_ack", 32'(cpu_ack_cnt - ack0), 0);
    check("t1_wq_full", 32'(wq_full), 0);

    // Overflow: five back-to-back pushes with memory stalled
    hold_ack = 1'b1;
    base = mem_acc_cnt;
    for (int i = 0; i < 5; i++) usb_write(32'h1000 + 32'(2 * i), 16'h2000 + 16'(i), i < 4);
    usb_quiet();
    @(negedge CLK_SYS);
    check("t2_full", 32'(wq_full), 1);
    check("t2_overflow", 32'(wq_overflow), 1);
    check("t2_stalled", 32'(mem_acc_cnt - base), 0);
    hold_ack = 1'b0;
    wait_drain(300, "t2");
    check("t2_mem_count", 32'(mem_acc_cnt - base), 4);
    check("t2_overflow_sticky", 32'(wq_overflow), 1);
    check("t2_not_full", 32'(wq_full), 0);

    // Burst read from odd address, first word stalled
    mem_model[32'h200] = 16'h1111;
    mem_model[32'h202] = 16'h2222;
    mem_model[32'h204] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      exp_mem.push_back('{we: 1'b0, addr: ADDR_W'(32'h200 + 32'(2 * i)), data: 16'h0});
      exp_rd.push_back(16'h1111 * 16'(i + 1));
    end
    usb_rd_ready = 1'b0;
    usb_read(32'h201, 16'd5);
    usb_quiet();
    check("t3_busy_set", 32'(usb_rd_busy), 1);
    consume_words(3, 1'b1);
    wait_drain(200, "t3");

    // Zero-length burst is ignored
    usb_read(32'h200, 16'd0);
    usb_quiet();
    check("t3_zero_len_busy", 32'(usb_rd_busy), 0);
    @(negedge CLK_SYS);
    check("t3_zero_len_req", 32'(mem_req), 0);

    // Round-robin: CPU reads interleave with a full USB write queue
    for (int i = 0; i < 3; i++) mem_model[32'h800 + 2 * i] = 16'hC000 + 16'(i);
    ack0 = cpu_ack_cnt;
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) usb_write(32'h400 + 32'(2 * i), 16'hD000 + 16'(i), 1'b0);
    usb_quiet();
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{we: 1'b1, addr: ADDR_W'(32'h400 + 32'(2 * i)), data: 16'hD000 + 16'(i)});
      if (i < 3) begin
        exp_mem.push_back('{we: 1'b0, addr: ADDR_W'(32'h800 + 32'(2 * i)), data: 16'h0});
        cpu_q.push_back('{we: 1'b0, addr: ADDR_W'(32'h800 + 32'(2 * i)), data: 16'hC000 + 16'(i)});
      end
    end
    hold_ack = 1'b0;
    wait_drain(400, "t4");
    check("t4_cpu_acks", 32'(cpu_ack_cnt - ack0), 3);

    // Read-after-write ordering
    mem_model[32'h300] = 16'h0000;
    usb_write(32'h300, 16'h5A5A, 1'b1);
    exp_mem.push_back('{we: 1'b0, addr: ADDR_W'(32'h300), data: 16'h0});
    exp_rd.push_back(16'h5A5A);
    usb_read(32'h300, 16'd2);
    usb_quiet();
    consume_words(1, 1'b0);
    wait_drain(200, "t5");

    // Reset in the middle of a stalled access
    hold_ack = 1'b1;
    for (int i = 0; i < 5; i++) usb_write(32'h500 + 32'(2 * i), 16'h1234, 1'b0);
    usb_read(32'h600, 16'd4);
    usb_quiet();
    check("t6_pre_req", 32'(mem_req), 1);
    check("t6_pre_busy", 32'(usb_rd_busy), 1);
    check("t6_pre_full", 32'(wq_full), 1);
    RESET_N = 1'b0;
    @(negedge CLK_SYS);
    RESET_N = 1'b1;
    check("t6_mem_req", 32'(mem_req), 0);
    check("t6_rd_busy", 32'(usb_rd_busy), 0);
    check("t6_wq_full", 32'(wq_full), 0);
    check("t6_wq_ovf", 32'(wq_overflow), 0);
    hold_ack = 1'b0;
    base = mem_acc_cnt;
    usb_write(32'h700, 16'h7777, 1'b1);
    usb_quiet();
    wait_drain(200, "t6");
    check("t6_mem_count", 32'(mem_acc_cnt - base), 1);
    check("exp_rd_left", 32'(exp_rd.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
